// File: rtl/sync_timing_generator.sv
// Single-axis video timing generator: position counter swept through active/front/sync/back phases.
// Latency: counter, phase, sync and display_enable registered together (zero skew); wrap is combinational.
// Backpressure: none; enable low freezes every register and forces wrap low.
module sync_timing_generator #(
  parameter int COUNTER_WIDTH = 11,
  parameter int ACTIVE        = 640,
  parameter int FRONT_PORCH   = 16,
  parameter int SYNC_WIDTH    = 96,
  parameter int BACK_PORCH    = 48,
  parameter bit SYNC_POLARITY = 1'b0
) (
  input  logic                     control_clock,
  input  logic                     reset_n,
  input  logic                     enable,
  output logic [COUNTER_WIDTH-1:0] counter_out,
  output logic                     sync,
  output logic                     display_enable,
  output logic [1:0]               phase,
  output logic                     wrap
);

  localparam int TOTAL     = ACTIVE + FRONT_PORCH + SYNC_WIDTH + BACK_PORCH;
  localparam int SYNC_START = ACTIVE + FRONT_PORCH;
  localparam int SYNC_END   = SYNC_START + SYNC_WIDTH;

  // Last position of each phase; a zero-length phase is never entered so its
  // boundary value is harmless even when it coincides with a neighbour's.
  localparam logic [COUNTER_WIDTH-1:0] LAST_ACTIVE = COUNTER_WIDTH'(ACTIVE - 1);
  localparam logic [COUNTER_WIDTH-1:0] LAST_FRONT  = COUNTER_WIDTH'(SYNC_START - 1);
  localparam logic [COUNTER_WIDTH-1:0] LAST_SYNC   = COUNTER_WIDTH'(SYNC_END - 1);
  localparam logic [COUNTER_WIDTH-1:0] LAST_POS    = COUNTER_WIDTH'(TOTAL - 1);

  // Reject timings the counter cannot represent or that have no active/sync region.
  if ((longint'(TOTAL) > (longint'(1) << COUNTER_WIDTH)) || (ACTIVE < 1) || (SYNC_WIDTH < 1) ||
      (FRONT_PORCH < 0) || (BACK_PORCH < 0)) begin : g_param_check
    $error("sync_timing_generator: illegal timing parameters");
  end

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  phase_t                     state;
  phase_t                     state_nxt;
  logic [COUNTER_WIDTH-1:0]   count;
  logic [COUNTER_WIDTH-1:0]   count_nxt;

  // Next position and next phase; a phase is left on the edge that leaves its last position.
  always_comb begin
    count_nxt = (count == LAST_POS) ? '0 : count + COUNTER_WIDTH'(1);
    state_nxt = state;
    case (state)
      PH_ACTIVE: if (count == LAST_ACTIVE) state_nxt = (FRONT_PORCH == 0) ? PH_SYNC : PH_FRONT;
      PH_FRONT:  if (count == LAST_FRONT)  state_nxt = PH_SYNC;
      PH_SYNC:   if (count == LAST_SYNC)   state_nxt = (BACK_PORCH == 0) ? PH_ACTIVE : PH_BACK;
      PH_BACK:   if (count == LAST_POS)    state_nxt = PH_ACTIVE;
      default:   state_nxt = PH_ACTIVE;
    endcase
  end

  // Counter, phase and the phase-decoded outputs all advance on the same enabled edge.
  always_ff @(posedge control_clock or negedge reset_n) begin
    if (!reset_n) begin
      count          <= '0;
      state          <= PH_ACTIVE;
      sync           <= ~SYNC_POLARITY;
      display_enable <= 1'b1;
    end else if (enable) begin
      count          <= count_nxt;
      state          <= state_nxt;
      sync           <= (state_nxt == PH_SYNC) ? SYNC_POLARITY : ~SYNC_POLARITY;
      display_enable <= (state_nxt == PH_ACTIVE);
    end
  end

  assign counter_out = count;
  assign phase       = state;
  // Gated by the count, so it stays low during reset even with enable high.
  assign wrap        = enable & (count == LAST_POS);

endmodule

// File: tb/tb_sync_timing_generator.sv
module tb_sync_timing_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_h = 1'b1, rst_c = 1'b1, rst_v = 1'b1;
  logic en_h = 1'b0, en_c = 1'b0;

  logic [10:0] h_cnt, p_cnt, z_cnt, cv_cnt;
  logic [3:0]  ch_cnt;
  logic [1:0]  h_ph, p_ph, z_ph, ch_ph, cv_ph;
  logic        h_sync, p_sync, z_sync, ch_sync, cv_sync;
  logic        h_de, p_de, z_de, ch_de, cv_de;
  logic        h_wrap, p_wrap, z_wrap, ch_wrap, cv_wrap;

  int vectors = 0;
  int miscompares = 0;

  // Defaults (horizontal VGA)
  sync_timing_generator u_h (
    .control_clock(clk), .reset_n(rst_h), .enable(en_h), .counter_out(h_cnt),
    .sync(h_sync), .display_enable(h_de), .phase(h_ph), .wrap(h_wrap));
  // Positive sync polarity
  sync_timing_generator #(.SYNC_POLARITY(1'b1)) u_p (
    .control_clock(clk), .reset_n(rst_h), .enable(en_h), .counter_out(p_cnt),
    .sync(p_sync), .display_enable(p_de), .phase(p_ph), .wrap(p_wrap));
  // Zero porches, TOTAL = 736
  sync_timing_generator #(.FRONT_PORCH(0), .BACK_PORCH(0)) u_z (
    .control_clock(clk), .reset_n(rst_h), .enable(en_h), .counter_out(z_cnt),
    .sync(z_sync), .display_enable(z_de), .phase(z_ph), .wrap(z_wrap));
  // Short horizontal (TOTAL = 10) driving a full-size VGA vertical instance
  sync_timing_generator #(.COUNTER_WIDTH(4), .ACTIVE(6), .FRONT_PORCH(1), .SYNC_WIDTH(2), .BACK_PORCH(1)) u_ch (
    .control_clock(clk), .reset_n(rst_c), .enable(en_c), .counter_out(ch_cnt),
    .sync(ch_sync), .display_enable(ch_de), .phase(ch_ph), .wrap(ch_wrap));
  sync_timing_generator #(.ACTIVE(480), .FRONT_PORCH(10), .SYNC_WIDTH(2), .BACK_PORCH(33)) u_cv (
    .control_clock(clk), .reset_n(rst_v), .enable(ch_wrap), .counter_out(cv_cnt),
    .sync(cv_sync), .display_enable(cv_de), .phase(cv_ph), .wrap(cv_wrap));

  // ---------------- reference model: positions as plain integers ----------------
  int m_h = 0, m_z = 0, m_ch = 0, m_cv = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_h)
    if (!rst_h) begin m_h <= 0; m_z <= 0; end
    else if (en_h) begin
      m_h <= (m_h + 1) % 800;
      m_z <= (m_z + 1) % 736;
    end

  always @(posedge clk or negedge rst_c)
    if (!rst_c) m_ch <= 0;
    else if (en_c) m_ch <= (m_ch + 1) % 10;

  always @(posedge clk or negedge rst_v)
    if (!rst_v) m_cv <= 0;
    else if (en_c && m_ch == 9) m_cv <= (m_cv + 1) % 525;

  function automatic int exp_phase(int c, int a, int f, int s);
    if (c < a)                return 0;
    else if (c < a + f)       return 1;
    else if (c < a + f + s)   return 2;
    else                      return 3;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask

  task automatic chk_inst(input string n, input logic [31:0] cnt, input logic s, input logic de,
                          input logic [1:0] ph, input logic w, input int m,
                          input int a, input int f, input int sw, input int tot,
                          input logic pol, input logic en);
    int p;
    p = exp_phase(m, a, f, sw);
    chk({n, ".count"}, cnt, 32'(m));
    chk({n, ".phase"}, 32'(ph), 32'(p));
    chk({n, ".de"}, 32'(de), 32'(p == 0));
    chk({n, ".sync"}, 32'(s), (p == 2) ? 32'(pol) : 32'(!pol));
    chk({n, ".wrap"}, 32'(w), 32'(en && (m == tot - 1)));
  endtask

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    chk_inst("h",  32'(h_cnt),  h_sync,  h_de,  h_ph,  h_wrap,  m_h,  640, 16, 96, 800, 1'b0, en_h);
    chk_inst("p",  32'(p_cnt),  p_sync,  p_de,  p_ph,  p_wrap,  m_h,  640, 16, 96, 800, 1'b1, en_h);
    chk_inst("z",  32'(z_cnt),  z_sync,  z_de,  z_ph,  z_wrap,  m_z,  640, 0,  96, 736, 1'b0, en_h);
    chk_inst("ch", 32'(ch_cnt), ch_sync, ch_de, ch_ph, ch_wrap, m_ch, 6,   1,  2,  10,  1'b0, en_c);
    chk_inst("cv", 32'(cv_cnt), cv_sync, cv_de, cv_ph, cv_wrap, m_cv, 480, 10, 2,  525, 1'b0, en_c && (m_ch == 9));
  end

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    int n_de, n_sl, smin, smax, n_f, n_b, n_w, wcnt, n_ps;
    int n_zs, zmin, zmax, n_z0, n_z13, zph640;
    int t, w1, w2, nw, f1, f2, prev, vsmin, vsmax, n_vs, n_vde;

    #1 rst_h = 1'b0; rst_c = 1'b0; rst_v = 1'b0;
    #2;
    chk("rst_h_cnt", 32'(h_cnt), 0);
    chk("rst_h_phase", 32'(h_ph), 0);
    chk("rst_h_de", 32'(h_de), 1);
    chk("rst_h_sync", 32'(h_sync), 1);
    chk("rst_p_sync", 32'(p_sync), 0);
    chk("rst_h_wrap", 32'(h_wrap), 0);
    chk("rst_cv_cnt", 32'(cv_cnt), 0);

    @(posedge clk); #2;
    rst_h = 1'b1; rst_c = 1'b1; rst_v = 1'b1; en_h = 1'b1; en_c = 1'b1;
    @(negedge clk) chk("post_release_cnt", 32'(h_cnt), 0);
    @(negedge clk) chk("first_edge_cnt", 32'(h_cnt), 1);

    // One full default line
    n_de = 0; n_sl = 0; smin = 9999; smax = -1; n_f = 0; n_b = 0; n_w = 0; wcnt = -1; n_ps = 0;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) @(negedge clk);
      if (h_de) n_de++;
      if (!h_sync) begin
        n_sl++;
        if (int'(h_cnt) < smin) smin = int'(h_cnt);
        if (int'(h_cnt) > smax) smax = int'(h_cnt);
      end
      if (h_ph == 2'd1) n_f++;
      if (h_ph == 2'd3) n_b++;
      if (h_wrap) begin n_w++; wcnt = int'(h_cnt); end
      if (p_sync) n_ps++;
    end
    chk("line_de_clocks", 32'(n_de), 640);
    chk("line_sync_clocks", 32'(n_sl), 96);
    chk("sync_first", 32'(smin), 656);
    chk("sync_last", 32'(smax), 751);
    chk("front_clocks", 32'(n_f), 16);
    chk("back_clocks", 32'(n_b), 48);
    chk("wrap_clocks", 32'(n_w), 1);
    chk("wrap_count", 32'(wcnt), 799);
    chk("pos_sync_high_clocks", 32'(n_ps), 96);

    // One full zero-porch line
    n_zs = 0; zmin = 9999; zmax = -1; n_z0 = 0; n_z13 = 0; zph640 = -1;
    for (int i = 0; i < 736; i++) begin
      @(negedge clk);
      if (!z_sync) begin
        n_zs++;
        if (int'(z_cnt) < zmin) zmin = int'(z_cnt);
        if (int'(z_cnt) > zmax) zmax = int'(z_cnt);
      end
      if (z_ph == 2'd0) n_z0++;
      if (z_ph == 2'd1 || z_ph == 2'd3) n_z13++;
      if (z_cnt == 11'd640) zph640 = int'(z_ph);
    end
    chk("zp_sync_clocks", 32'(n_zs), 96);
    chk("zp_sync_first", 32'(zmin), 640);
    chk("zp_sync_last", 32'(zmax), 735);
    chk("zp_active_clocks", 32'(n_z0), 640);
    chk("zp_porch_clocks", 32'(n_z13), 0);
    chk("zp_phase_at_640", 32'(zph640), 2);

    // enable toggled every other cycle: two wraps 1600 clocks apart
    t = 0; w1 = -1; w2 = -1; nw = 0;
    while (w2 < 0 && t < 5000) begin
      @(posedge clk); #2 en_h = ~en_h;
      @(negedge clk);
      if (h_wrap) begin
        nw++;
        if (w1 < 0) w1 = t; else w2 = t;
      end
      t++;
    end
    chk("toggle_line_clocks", 32'(w2 - w1), 1600);
    chk("toggle_wrap_pulses", 32'(nw), 2);
    @(posedge clk); #2 en_h = 1'b1;

    // Asynchronous reset mid-line at count 300
    t = 0;
    while (h_cnt != 11'd300 && t < 2000) begin @(negedge clk); t++; end
    chk("reach_300", 32'(h_cnt), 300);
    #2 rst_h = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(h_cnt), 0);
    chk("mid_rst_phase", 32'(h_ph), 0);
    chk("mid_rst_de", 32'(h_de), 1);
    chk("mid_rst_sync", 32'(h_sync), 1);
    chk("mid_rst_psync", 32'(p_sync), 0);
    chk("mid_rst_wrap", 32'(h_wrap), 0);
    chk("mid_rst_zcnt", 32'(z_cnt), 0);
    @(posedge clk); #2 rst_h = 1'b1;
    @(negedge clk) chk("resume_cnt0", 32'(h_cnt), 0);
    @(negedge clk) chk("resume_cnt1", 32'(h_cnt), 1);

    // Cascade: measure one full frame between two vertical returns to line 0
    t = 0; f1 = -1; f2 = -1; prev = int'(cv_cnt);
    vsmin = 9999; vsmax = -1; n_vs = 0; n_vde = 0;
    while (f2 < 0 && t < 12000) begin
      @(negedge clk);
      if (prev != 0 && cv_cnt == 11'd0) begin
        if (f1 < 0) f1 = cyc; else f2 = cyc;
      end
      if (f1 >= 0 && f2 < 0) begin
        if (!cv_sync) begin
          n_vs++;
          if (int'(cv_cnt) < vsmin) vsmin = int'(cv_cnt);
          if (int'(cv_cnt) > vsmax) vsmax = int'(cv_cnt);
        end
        if (cv_de) n_vde++;
      end
      prev = int'(cv_cnt);
      t++;
    end
    chk("frame_clocks", 32'(f2 - f1), 5250);
    chk("vsync_first_line", 32'(vsmin), 490);
    chk("vsync_last_line", 32'(vsmax), 491);
    chk("vsync_clocks", 32'(n_vs), 20);
    chk("vde_clocks", 32'(n_vde), 4800);

    // Vertical reset at line 200
    t = 0;
    while (cv_cnt != 11'd200 && t < 6000) begin @(negedge clk); t++; end
    chk("reach_line_200", 32'(cv_cnt), 200);
    #2 rst_v = 1'b0;
    #1;
    chk("v_rst_cnt", 32'(cv_cnt), 0);
    chk("v_rst_sync", 32'(cv_sync), 1);
    chk("v_rst_de", 32'(cv_de), 1);
    @(posedge clk); #2 rst_v = 1'b1;
    t = 0;
    while (cv_cnt == 11'd0 && t < 50) begin @(negedge clk); t++; end
    chk("v_resume_line", 32'(cv_cnt), 1);
    chk("v_resume_h_zero", 32'(ch_cnt), 0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_timing_generator.md
# sync_timing_generator

Parametrised, single-axis video timing generator that supersedes the fixed-threshold horizontal sync generator. It sweeps a position counter through four ordered phases (active, front porch, sync, back porch) and produces sync with selectable polarity, a display-enable, the current phase, and a wrap strobe. The same block serves both the horizontal axis (enable tied high) and the vertical axis (enable driven by the horizontal instance's wrap). Together, one horizontal and one vertical instance form the complete VGA frame timing.

## Interface
- COUNTER_WIDTH, 11, width of the position counter
- ACTIVE, 640, visible positions per period (≥1)
- FRONT_PORCH, 16, positions between active and sync (≥0)
- SYNC_WIDTH, 96, sync pulse length (≥1)
- BACK_PORCH, 48, positions after sync (≥0)
- SYNC_POLARITY, 0, asserted level of sync (0 = active-low)
- control_clock  in  1  pixel/line clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  advance the position by one on this clock edge
- counter_out  out  COUNTER_WIDTH  current position, 0..TOTAL-1
- sync  out  1  sync pulse, level per SYNC_POLARITY
- display_enable  out  1  high while the position is in the active phase
- phase  out  2  0 = ACTIVE, 1 = FRONT, 2 = SYNC, 3 = BACK
- wrap  out  1  last-position strobe, used for cascading

## Operation
- TOTAL = ACTIVE + FRONT_PORCH + SYNC_WIDTH + BACK_PORCH. Elaboration must fail if TOTAL > 2^COUNTER_WIDTH, ACTIVE = 0 or SYNC_WIDTH = 0.
- Phase boundaries:
  - ACTIVE covers 0..ACTIVE-1.
  - FRONT covers ACTIVE..ACTIVE+FRONT_PORCH-1.
  - SYNC covers S0..S0+SYNC_WIDTH-1, where S0 = ACTIVE+FRONT_PORCH.
  - BACK covers the remaining positions up to TOTAL-1.
- Phase FSM:
  - Registered; transitions ACTIVE→FRONT→SYNC→BACK→ACTIVE, each taken on the enabled edge that leaves the last position of the current phase.
  - A phase with zero length is skipped: FRONT_PORCH = 0 gives ACTIVE→SYNC; BACK_PORCH = 0 gives SYNC→ACTIVE.
- Counter: on an enabled edge it increments; at TOTAL-1 it returns to 0. There is no other wrap path, and the counter never takes values ≥ TOTAL.
- sync, display_enable and phase are registered and always describe the position currently shown on counter_out; all three are updated on the same edge as the counter.
  - sync = SYNC_POLARITY when phase = SYNC, otherwise ~SYNC_POLARITY.
  - display_enable = (phase == ACTIVE).
- wrap is combinational: wrap = enable & (counter_out == TOTAL-1). It is the only combinational output.
- Cascade: connect the vertical instance's enable to the horizontal instance's wrap. The vertical instance then advances on the same edge on which the horizontal counter returns to 0.
- enable low holds every register. wrap is 0 while enable is low.

## Timing
- Reset (reset_n low) takes effect immediately, without a clock edge, and applies at any point including mid-period. While it is held, outputs are:
  - counter_out = 0
  - phase = ACTIVE
  - display_enable = 1
  - sync = ~SYNC_POLARITY
  - wrap = 0, because it is gated by the count rather than by enable.
- After reset_n is released, the first enabled edge moves the position to 1.
- Latency: sync, display_enable and phase have zero cycles of skew relative to counter_out. wrap asserts in the same cycle as counter_out = TOTAL-1 with enable high.
- One full period takes exactly TOTAL enabled edges.
- Simultaneous end of a phase and end of the period (BACK_PORCH = 0 at TOTAL-1): the next edge gives counter 0, phase ACTIVE and sync deasserted.

## Test plan
- Defaults, enable = 1, reset released:
  - counter_out runs 0..799 and then returns to 0.
  - display_enable is high exactly for counts 0..639.
  - sync is low exactly for counts 656..751.
  - phase is 1 for counts 640..655 and 3 for counts 752..799.
  - wrap is high only at count 799.
- enable toggled every other cycle: the counter advances only on enabled edges, and one line takes 1600 clocks. wrap is high for 1 clock at count 799, only in a cycle where enable = 1.
- Cascade: horizontal instance with defaults; vertical instance with ACTIVE = 480, FRONT_PORCH = 10, SYNC_WIDTH = 2, BACK_PORCH = 33 and enable = horizontal wrap.
  - The vertical count increments on the horizontal 799→0 edge.
  - Vertical sync is low for lines 490..491.
  - One frame takes 525 × 800 = 420000 clocks.
- SYNC_POLARITY = 1 with the other parameters at default: sync is high for counts 656..751 and low everywhere else, including during reset.
- FRONT_PORCH = 0 and BACK_PORCH = 0 (TOTAL = 736):
  - phase goes 0→2 at count 640.
  - sync is asserted at counts 640..735.
  - phase returns to 0 at count 0.
- reset_n pulsed low at count 300 between clock edges:
  - Outputs go to their reset values immediately.
  - After release, counting resumes 0→1 on the first enabled edge.
  - Vertical instance reset at line 200 returns to line 0 the same way.
